// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states,
// default memory depth and the alignment helpers used by the request decoder.
package lsu_pkg;

   localparam int MEM_WORDS_DEFAULT = 1000;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_WAIT,
      ST_WR,
      ST_RESP
   } state_e;

   // The reserved encoding behaves as a full word everywhere.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (size == SIZE_HALF)
         mis = addr_lo[0];
      else if (is_word(size))
         mis = (addr_lo != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends a loaded sub-word, and
// merges store data into the old memory word for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] rd_word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_val_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane  = rd_word_i[{addr_lo_i, 3'b000} +: 8];
      half_lane  = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
      load_val_o = rd_word_i;
      case (size_i)
         SIZE_BYTE: load_val_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_val_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
         default:   load_val_o = rd_word_i;
      endcase
   end

   // Each lane takes store data when addressed, otherwise keeps the old byte.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] wr_byte;

      assign lane_hit = (size_i == SIZE_BYTE) ? (addr_lo_i == 2'(gi)) :
                        (size_i == SIZE_HALF) ? (addr_lo_i[1] == 1'(gi / 2)) : 1'b1;
      assign wr_byte  = (size_i == SIZE_BYTE) ? wdata_i[7:0] :
                        (size_i == SIZE_HALF) ? wdata_i[8*(gi%2) +: 8] : wdata_i[8*gi +: 8];
      assign merged_o[8*gi +: 8] = lane_hit ? wr_byte : rd_word_i[8*gi +: 8];
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a pipeline request port to a word-addressed data memory.
// Define LSU_BOUNDS_CHECK_EN to reject word indices at or beyond MEM_WORDS.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Req_valid,
   output logic        Req_ready,
   input  logic        Req_write,
   input  logic [1:0]  Req_size,
   input  logic        Req_signed,
   input  logic [31:0] Req_addr,
   input  logic [31:0] Req_wdata,
   output logic        Resp_valid,
   output logic [31:0] Resp_rdata,
   output logic        Access_err,
   output logic [31:0] Mem_address,
   output logic [31:0] Mem_write_data,
   output logic        Mem_read,
   output logic        Mem_write,
   input  logic [31:0] Mem_read_data
);

   if (MEM_WORDS <= 0) begin : g_depth_check
      $error("MEM_WORDS must be positive");
   end

   state_e      state_q, state_d;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q, wdata_q;
   logic [1:0]  size_q, addr_lo_q;
   logic        write_q, signed_q, err_q;
   logic        accept, req_err, oob;
   logic [31:0] load_val, merged;

   assign accept = Req_valid & (state_q == ST_IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
   assign oob = ({2'b00, Req_addr[31:2]} >= 32'($unsigned(MEM_WORDS)));
`else
   assign oob = 1'b0;
`endif

   assign req_err = is_misaligned(Req_size, Req_addr[1:0]) | oob;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (Req_valid) begin
               if (req_err)                                state_d = ST_RESP;
               else if (Req_write && is_word(Req_size))    state_d = ST_WR;
               else                                        state_d = ST_RD;
            end
         end
         ST_RD:      state_d = ST_RD_WAIT;
         ST_RD_WAIT: state_d = write_q ? ST_WR : ST_RESP;
         ST_WR:      state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   lsu_lane_align u_lane_align (
      .rd_word_i  (Mem_read_data),
      .addr_lo_i  (addr_lo_q),
      .size_i     (size_q),
      .sign_ext_i (signed_q),
      .wdata_i    (wdata_q),
      .load_val_o (load_val),
      .merged_o   (merged)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         addr_lo_q   <= '0;
         write_q     <= 1'b0;
         signed_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            mem_addr_q <= {2'b00, Req_addr[31:2]};
            write_q    <= Req_write;
            size_q     <= Req_size;
            signed_q   <= Req_signed;
            addr_lo_q  <= Req_addr[1:0];
            wdata_q    <= Req_wdata;
            err_q      <= req_err;
            if (Req_write && is_word(Req_size) && !req_err)
               mem_wdata_q <= Req_wdata;
         end
         // Memory data is valid during RD_WAIT: either the load result or the RMW base.
         if (state_q == ST_RD_WAIT) begin
            if (write_q) mem_wdata_q <= merged;
            else         rdata_q     <= load_val;
         end else if (state_d == ST_RESP) begin
            rdata_q <= '0;
         end
      end
   end

   always_comb begin
      Req_ready      = (state_q == ST_IDLE);
      Mem_read       = (state_q == ST_RD);
      Mem_write      = (state_q == ST_WR);
      Resp_valid     = (state_q == ST_RESP);
      Access_err     = (state_q == ST_RESP) & err_q;
      Mem_address    = mem_addr_q;
      Mem_write_data = mem_wdata_q;
      Resp_rdata     = rdata_q;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1000, meaning the number of 32-bit words in the attached data memory.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Req_valid, input, 1, pipeline access request present.
REQ-005 SHALL have port Req_ready, output, 1, request accepted on this edge if Req_valid.
REQ-006 SHALL have port Req_write, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port Req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved, treated as word.
REQ-008 SHALL have port Req_signed, input, 1, sign-extend sub-word loads.
REQ-009 SHALL have ports Req_addr (byte address) and Req_wdata, input, 32 each.
REQ-010 SHALL have ports Resp_valid (output, 1), Resp_rdata (output, 32) and Access_err (output, 1).
REQ-011 SHALL have memory-side ports Mem_address (output, 32, word index), Mem_write_data (output, 32), Mem_read (output, 1), Mem_write (output, 1) and Mem_read_data (input, 32).

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, RD, RD_WAIT, WR and RESP; all outputs SHALL be registered or decoded from state.
REQ-013 SHALL assert Req_ready only in IDLE; acceptance is Req_valid AND Req_ready at a rising edge, and inputs SHALL be captured then.
REQ-014 SHALL set Mem_address = Req_addr[31:2], zero-extended, held stable from RD or WR until leaving RESP.
REQ-015 SHALL treat the request as misaligned when half and addr[0]=1, or word and addr[1:0]≠0.
REQ-016 SHALL, on a misaligned request, go IDLE->RESP with Access_err=1 and no Mem_read or Mem_write.
REQ-017 SHALL, on a load, go IDLE->RD (Mem_read=1)->RD_WAIT->RESP->IDLE.
REQ-018 SHALL, on a load, capture Mem_read_data at the edge leaving RD_WAIT and extract the byte lane addr[1:0] (little-endian) or half lane addr[1]; sign- or zero-extension SHALL follow Req_signed.
REQ-019 SHALL, on a word store, go IDLE->WR (Mem_write=1, Mem_write_data=Req_wdata)->RESP->IDLE.
REQ-020 SHALL, on a byte or half store, perform read-modify-write: IDLE->RD->RD_WAIT->WR, replacing only the addressed lane with Req_wdata low bits.
REQ-021 SHALL hold Resp_valid=1 for exactly one cycle (RESP); Resp_rdata=0 for stores and errors; Resp_rdata SHALL hold its value until the next RESP.
REQ-022 SHALL never assert Mem_read and Mem_write in the same cycle.
REQ-023 SHALL give load response latency of 3 cycles after the acceptance edge, word store 2, sub-word store 4, error 1.
REQ-024 SHALL keep Req_ready low in RESP; back-to-back requests SHALL incur exactly one IDLE cycle between responses.

Reset
REQ-025 SHALL, while Reset_n=0, force state IDLE and Req_ready=1, and clear Resp_valid, Resp_rdata, Access_err, Mem_address, Mem_write_data, Mem_read and Mem_write to 0 asynchronously.
REQ-026 SHALL abort an in-flight access on mid-operation reset: no Mem_write after Reset_n falls and no response after release.

Configuration
REQ-027 SHALL, with LSU_BOUNDS_CHECK_EN defined, treat word index ≥ MEM_WORDS as an error handled like REQ-016.
REQ-028 SHALL, without LSU_BOUNDS_CHECK_EN, omit the bounds comparator and issue out-of-range accesses unchanged.

Structure
REQ-029 SHALL place the size encodings, the FSM state enumeration and the MEM_WORDS default in shared package lsu_pkg.
REQ-030 SHALL implement lane extract/merge in one combinational sub-module lsu_lane_align (inputs: word, addr[1:0], size, signed, wdata; outputs: load value, merged word).

Verification
REQ-031 SHALL cover: memory word 5 = 0x80FF1234; load byte signed at addr 0x17 -> Resp_rdata 0xFFFFFF80, 3 cycles after acceptance.
REQ-032 SHALL cover: store half 0xBEEF at addr 0x16 over word 5 = 0x80FF1234 -> Mem_write with data 0xBEEF1234; reload word at 0x14 returns 0xBEEF1234.
REQ-033 SHALL cover: load word at addr 0x13 -> Access_err=1, Resp_valid one cycle, Mem_read and Mem_write never asserted.
REQ-034 SHALL cover: LSU_BOUNDS_CHECK_EN defined, load at 0xFA0 (index 1000) -> Access_err=1; macro undefined -> Mem_read with Mem_address 1000.
REQ-035 SHALL cover: Reset_n pulsed low during RD_WAIT of a sub-word store -> no Mem_write pulse; after release Req_ready=1 and all outputs 0.
REQ-036 SHALL cover: Req_valid held high for 4 word stores -> 4 single-cycle Resp_valid pulses spaced 3 cycles apart; Mem_read and Mem_write never both 1.
